ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative MIPS multiply/divide unit in the EX stage. Consumes the operands and opcode held in the ID/EX pipeline register and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. Asserts a stall toward the hazard unit while an operation is in flight. Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

Parameters:
XLEN, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
MD_Start  in  1  request from ID/EX; accepted only in IDLE
MD_Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
MD_Src_A  in  XLEN  rs operand (forwarded)
MD_Src_B  in  XLEN  rt operand (forwarded)
MD_Flush  in  1  abort in-flight op (branch/exception flush)
MD_WriteHi  in  1  MTHI strobe
MD_WriteLo  in  1  MTLO strobe
MD_WData  in  XLEN  MTHI/MTLO data
MD_Busy  out  1  stall request; high while state != IDLE
MD_Done  out  1  one-cycle pulse when HI/LO is updated by an op
MD_Hi  out  XLEN  HI register
MD_Lo  out  XLEN  LO register

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, counter=0, MD_Busy=0, MD_Done=0, MD_Hi=0, MD_Lo=0, datapath registers=0. Reset mid-operation discards the op.
- States: IDLE, CALC, FIX.
- IDLE: on MD_Start=1, latch |A|,|B| (signed ops) or raw (unsigned ops), result-sign flags and op; go to CALC with counter=0. Otherwise stay.
- CALC: one radix-2 step per cycle. Multiply is shift-add on a 2*XLEN accumulator. Divide is restoring shift-subtract. Counter increments each step. After step XLEN-1 go to FIX.
- FIX: apply sign correction and write HI/LO. Multiply: {HI,LO}=product. Divide: LO=quotient, HI=remainder. Remainder takes the dividend's sign. Go to IDLE. MD_Done=1 on the cycle after the FIX edge, for exactly one cycle.
- Latency: start accepted at edge t0. MD_Busy is high from t0+ through the edge t0+XLEN+1. HI/LO are valid and MD_Done=1 after edge t0+XLEN+1 (33 edges for XLEN=32).
- MD_Start while busy is ignored. The hazard unit is required to hold the instruction.
- Divide by zero: LO=all ones, HI=dividend (unsigned value for DIVU, signed value for DIV). Completes with normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MD_Flush in CALC/FIX: return to IDLE next edge, HI/LO unchanged, no MD_Done. MD_Flush in IDLE together with MD_Start: flush wins and the start is dropped.
- MTHI/MTLO:
  - Take effect in IDLE only; ignored while busy.
  - If simultaneous with an accepted MD_Start, the write lands now and is later overwritten by the op result.
  - Both strobes may assert together.
- MD_Hi/MD_Lo are direct register outputs and never show partial results.
- Arithmetic is modulo 2^XLEN per half. No overflow exceptions.

Optional Feature:
MD_EARLY_OUT_EN
- Defined: in CALC for a multiply, if the remaining unshifted multiplier bits are all zero, go to FIX on the next edge. Minimum latency is 2 edges, e.g. multiplier 0 gives Done after t0+2. Divide latency is unchanged.
- Undefined: all ops take fixed XLEN+1 edges. The early-out logic is absent.

Decomposition:
- Shared package mips_pkg holds:
  - MD_Op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - md_state_t enum (IDLE, CALC, FIX)
  - XLEN default
- One sub-module, md_iter_core: the combinational single-step datapath (add/subtract, shift, quotient bit). ex_muldiv owns the FSM, counter, sign fixup and HI/LO registers.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=2 -> Busy for 33 cycles, then Done pulse, HI=0x00000001, LO=0xFFFFFFFE.
2. MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x00001234. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Start MULT, assert MD_Flush 10 cycles later -> Busy=0 next cycle, no Done, HI/LO keep prior values. Repeat with rst=0 instead -> all outputs 0.
5. MTHI 0xAAAA0000 and MTLO 0x5555 in IDLE -> HI/LO updated next edge. Same strobes while Busy -> ignored. MD_Start while Busy -> no second op.
6. With MD_EARLY_OUT_EN: MULTU A=5, B=0 -> Done after 2 edges, HI=LO=0. Without the macro -> 33 edges.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: multiply/divide opcodes, FSM states and default width.
package mips_pkg;

  localparam int unsigned MD_XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Combinational single radix-2 step: shift-add multiply or restoring shift-subtract divide.
module md_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [2*XLEN-1:0] i_opa,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc,
  output logic [2*XLEN-1:0] o_opa,
  output logic [XLEN-1:0]   o_opb
);

  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_qbit;

  // Partial remainder < divisor, so the shifted value fits XLEN+1 bits and the
  // successful difference always fits XLEN bits.
  assign w_rem_sh = {i_acc[XLEN-1:0], i_opb[XLEN-1]};
  assign w_qbit   = (w_rem_sh >= {1'b0, i_opa[XLEN-1:0]});
  assign w_diff   = w_rem_sh[XLEN-1:0] - i_opa[XLEN-1:0];

  always_comb begin
    o_acc = i_acc;
    o_opa = i_opa;
    o_opb = i_opb;
    if (i_is_div) begin
      o_acc[XLEN-1:0] = w_qbit ? w_diff : w_rem_sh[XLEN-1:0];
      o_opb           = {i_opb[XLEN-2:0], w_qbit};
    end else begin
      if (i_opb[0]) o_acc = i_acc + i_opa;
      o_opa = i_opa << 1;
      o_opb = i_opb >> 1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO access.
// Define MD_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MD_Start,
  input  logic [1:0]      MD_Op,
  input  logic [XLEN-1:0] MD_Src_A,
  input  logic [XLEN-1:0] MD_Src_B,
  input  logic            MD_Flush,
  input  logic            MD_WriteHi,
  input  logic            MD_WriteLo,
  input  logic [XLEN-1:0] MD_WData,
  output logic            MD_Busy,
  output logic            MD_Done,
  output logic [XLEN-1:0] MD_Hi,
  output logic [XLEN-1:0] MD_Lo
);

  localparam int unsigned      DW        = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_acc, r_opa;
  logic [XLEN-1:0]  r_opb;
  logic             r_is_div, r_neg_res, r_neg_rem, r_div0;
  logic             r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic [XLEN-1:0]  r_hi, r_lo;

  md_op_t           w_op;
  logic             w_start, w_is_div, w_signed, w_sa, w_sb, w_calc_last;
  logic [XLEN-1:0]  w_abs_a, w_abs_b;
  logic [DW-1:0]    w_acc_nxt, w_opa_nxt, w_prod;
  logic [XLEN-1:0]  w_opb_nxt, w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_op     = md_op_t'(MD_Op);
  assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_start  = (r_state == IDLE) && MD_Start && !MD_Flush;
  assign w_sa     = w_signed && MD_Src_A[XLEN-1];
  assign w_sb     = w_signed && MD_Src_B[XLEN-1];
  assign w_abs_a  = w_sa ? (~MD_Src_A + XLEN'(1)) : MD_Src_A;
  assign w_abs_b  = w_sb ? (~MD_Src_B + XLEN'(1)) : MD_Src_B;

`ifdef MD_EARLY_OUT_EN
  assign w_calc_last = (r_cnt == LAST_STEP) || (!r_is_div && (r_opb == '0));
`else
  assign w_calc_last = (r_cnt == LAST_STEP);
`endif

  md_iter_core #(.XLEN(XLEN)) u_core (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opa    (r_opa),
    .i_opb    (r_opb),
    .o_acc    (w_acc_nxt),
    .o_opa    (w_opa_nxt),
    .o_opb    (w_opb_nxt)
  );

  // Sign fixup of magnitudes; divide-by-zero forces an all-ones quotient.
  assign w_prod   = r_neg_res ? (~r_acc + DW'(1)) : r_acc;
  assign w_quo    = r_div0 ? '1 : (r_neg_res ? (~r_opb + XLEN'(1)) : r_opb);
  assign w_rem    = r_neg_rem ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  assign w_res_hi = r_is_div ? w_rem : w_prod[DW-1:XLEN];
  assign w_res_lo = r_is_div ? w_quo : w_prod[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_nxt = CALC;
      CALC:    w_state_nxt = MD_Flush ? IDLE : (w_calc_last ? FIX : CALC);
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (r_state == FIX) && !MD_Flush;
  end

  // Operand latch on accept, then one datapath step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= DW'(w_is_div ? w_abs_b : w_abs_a);
      r_opb     <= w_is_div ? w_abs_a : w_abs_b;
      r_is_div  <= w_is_div;
      r_neg_res <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      r_div0    <= w_is_div && (MD_Src_B == '0);
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_nxt;
      r_opa <= w_opa_nxt;
      r_opb <= w_opb_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == FIX) && !MD_Flush) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (r_state == IDLE) begin
      if (MD_WriteHi) r_hi <= MD_WData;
      if (MD_WriteLo) r_lo <= MD_WData;
    end
  end

  assign MD_Busy = r_busy;
  assign MD_Done = r_done;
  assign MD_Hi   = r_hi;
  assign MD_Lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic results, latency, flush/reset abort, MTHI/MTLO.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        MD_Start, MD_Flush, MD_WriteHi, MD_WriteLo;
  logic [1:0]  MD_Op;
  logic [31:0] MD_Src_A, MD_Src_B, MD_WData;
  logic        MD_Busy, MD_Done;
  logic [31:0] MD_Hi, MD_Lo;

  int n_vec = 0;
  int n_err = 0;

`ifdef MD_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 33;
`endif

  ex_muldiv dut (
    .clk(clk), .rst(rst), .MD_Start(MD_Start), .MD_Op(MD_Op),
    .MD_Src_A(MD_Src_A), .MD_Src_B(MD_Src_B), .MD_Flush(MD_Flush),
    .MD_WriteHi(MD_WriteHi), .MD_WriteLo(MD_WriteLo), .MD_WData(MD_WData),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Hi(MD_Hi), .MD_Lo(MD_Lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits from the current negedge until Done, counting edges; bounded.
  task automatic wait_done(inout int lat, output int busy_bad);
    busy_bad = 0;
    while (!MD_Done && lat < 100) begin
      if (!MD_Busy) busy_bad++;
      tick();
      lat++;
    end
  endtask

  // Issues one op at the current negedge and returns edges from accept to Done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad);
    MD_Op = op; MD_Src_A = a; MD_Src_B = b; MD_Start = 1'b1;
    tick();
    MD_Start = 1'b0;
    lat = 0;
    wait_done(lat, busy_bad);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    MD_Start = 0; MD_Flush = 0; MD_WriteHi = 0; MD_WriteLo = 0;
    MD_Op = 2'b00; MD_Src_A = 0; MD_Src_B = 0; MD_WData = 0;
    repeat (3) tick();
    n_vec++;
    if ({MD_Busy, MD_Done, MD_Hi, MD_Lo} !== 66'd0) begin
      n_err++; $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, expected all 0",
                        MD_Busy, MD_Done, MD_Hi, MD_Lo);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    logic [1:0]  ops [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
    logic [31:0] av  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] bv  [4] = '{32'h2, 32'h7, 32'hFFFFFFFF, 32'h10};
    logic [31:0] eh  [4] = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h1};
    logic [31:0] el  [4] = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'h1, 32'h23456780};
    int lat, bb;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], lat, bb);
      n_vec++;
      if (lat !== 33 || bb !== 0) begin
        n_err++; $display("FAIL mult%0d_latency: got %0d edges (%0d idle samples), expected 33 busy", i, lat, bb);
      end
      n_vec++;
      if (MD_Hi !== eh[i] || MD_Lo !== el[i]) begin
        n_err++; $display("FAIL mult%0d_result: got %h_%h expected %h_%h", i, MD_Hi, MD_Lo, eh[i], el[i]);
      end
      n_vec++;
      if (MD_Busy !== 1'b0) begin
        n_err++; $display("FAIL mult%0d_busy_at_done: got %b expected 0", i, MD_Busy);
      end
      tick();
      n_vec++;
      if (MD_Done !== 1'b0) begin
        n_err++; $display("FAIL mult%0d_done_pulse: got %b expected 0", i, MD_Done);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] av  [5] = '{32'hFFFFFFF9, 32'h1234, 32'h80000000, 32'd100, 32'hFFFFFFF0};
    logic [31:0] bv  [5] = '{32'h2, 32'h0, 32'hFFFFFFFF, 32'd7, 32'h0};
    logic [31:0] eh  [5] = '{32'hFFFFFFFF, 32'h1234, 32'h0, 32'd2, 32'hFFFFFFF0};
    logic [31:0] el  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd14, 32'hFFFFFFFF};
    int lat, bb;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], lat, bb);
      n_vec++;
      if (lat !== 33 || bb !== 0) begin
        n_err++; $display("FAIL div%0d_latency: got %0d edges (%0d idle samples), expected 33 busy", i, lat, bb);
      end
      n_vec++;
      if (MD_Hi !== eh[i] || MD_Lo !== el[i]) begin
        n_err++; $display("FAIL div%0d_result: got hi=%h lo=%h expected hi=%h lo=%h", i, MD_Hi, MD_Lo, eh[i], el[i]);
      end
      tick();
    end
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, bb);
    n_vec++;
    if (MD_Hi !== 32'h1 || MD_Lo !== 32'hFFFFFFFD) begin
      n_err++; $display("FAIL div_pos_by_neg: got hi=%h lo=%h expected hi=00000001 lo=fffffffd", MD_Hi, MD_Lo);
    end
    tick();
  endtask

  task automatic test_flush();
    int done_seen;
    MD_WData = 32'h11111111; MD_WriteHi = 1; tick(); MD_WriteHi = 0;
    MD_WData = 32'h22222222; MD_WriteLo = 1; tick(); MD_WriteLo = 0;
    MD_Op = 2'b00; MD_Src_A = 3; MD_Src_B = 3; MD_Start = 1;
    tick();
    MD_Start = 0;
    repeat (10) tick();
    MD_Flush = 1; tick(); MD_Flush = 0;
    n_vec++;
    if (MD_Busy !== 1'b0) begin
      n_err++; $display("FAIL flush_busy: got %b expected 0", MD_Busy);
    end
    done_seen = 0;
    repeat (40) begin
      if (MD_Done) done_seen++;
      tick();
    end
    n_vec++;
    if (done_seen !== 0 || MD_Hi !== 32'h11111111 || MD_Lo !== 32'h22222222) begin
      n_err++; $display("FAIL flush_no_result: got done=%0d hi=%h lo=%h expected 0 11111111 22222222",
                        done_seen, MD_Hi, MD_Lo);
    end
    // Flush together with a start in IDLE drops the start.
    MD_Start = 1; MD_Flush = 1; tick(); MD_Start = 0; MD_Flush = 0;
    n_vec++;
    if (MD_Busy !== 1'b0) begin
      n_err++; $display("FAIL flush_start_idle: got busy=%b expected 0", MD_Busy);
    end
    MD_Start = 1; tick(); MD_Start = 0;
    repeat (10) tick();
    rst = 0; tick(); rst = 1;
    n_vec++;
    if ({MD_Busy, MD_Done, MD_Hi, MD_Lo} !== 66'd0) begin
      n_err++; $display("FAIL reset_midop: got busy=%b done=%b hi=%h lo=%h expected all 0",
                        MD_Busy, MD_Done, MD_Hi, MD_Lo);
    end
    done_seen = 0;
    repeat (40) begin
      if (MD_Done || MD_Busy) done_seen++;
      tick();
    end
    n_vec++;
    if (done_seen !== 0) begin
      n_err++; $display("FAIL reset_discard: got %0d busy/done samples expected 0", done_seen);
    end
  endtask

  task automatic test_mthi_mtlo();
    int lat, bb, extra;
    MD_WData = 32'hAAAA0000; MD_WriteHi = 1; tick(); MD_WriteHi = 0;
    n_vec++;
    if (MD_Hi !== 32'hAAAA0000) begin
      n_err++; $display("FAIL mthi_idle: got %h expected aaaa0000", MD_Hi);
    end
    MD_WData = 32'h00005555; MD_WriteLo = 1; tick(); MD_WriteLo = 0;
    n_vec++;
    if (MD_Lo !== 32'h00005555 || MD_Hi !== 32'hAAAA0000) begin
      n_err++; $display("FAIL mtlo_idle: got hi=%h lo=%h expected aaaa0000 00005555", MD_Hi, MD_Lo);
    end
    MD_WData = 32'h0F0F0F0F; MD_WriteHi = 1; MD_WriteLo = 1; tick(); MD_WriteHi = 0; MD_WriteLo = 0;
    n_vec++;
    if (MD_Hi !== 32'h0F0F0F0F || MD_Lo !== 32'h0F0F0F0F) begin
      n_err++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 0f0f0f0f", MD_Hi, MD_Lo);
    end
    // MTLO lands with the accepted start, then the product overwrites it.
    MD_Op = 2'b01; MD_Src_A = 2; MD_Src_B = 3; MD_Start = 1;
    MD_WData = 32'h777; MD_WriteLo = 1;
    tick();
    MD_Start = 0; MD_WriteLo = 0;
    lat = 0;
    n_vec++;
    if (MD_Lo !== 32'h777 || MD_Busy !== 1'b1) begin
      n_err++; $display("FAIL mtlo_with_start: got lo=%h busy=%b expected 00000777 1", MD_Lo, MD_Busy);
    end
    MD_WData = 32'hDEAD; MD_WriteHi = 1; tick(); MD_WriteHi = 0; lat++;
    n_vec++;
    if (MD_Hi !== 32'h0F0F0F0F) begin
      n_err++; $display("FAIL mthi_busy_ignored: got %h expected 0f0f0f0f", MD_Hi);
    end
    MD_Op = 2'b11; MD_Src_A = 9; MD_Src_B = 3; MD_Start = 1; tick(); MD_Start = 0; lat++;
    wait_done(lat, bb);
    n_vec++;
    if (lat !== 33 || MD_Hi !== 32'h0 || MD_Lo !== 32'h6) begin
      n_err++; $display("FAIL start_while_busy: got lat=%0d hi=%h lo=%h expected 33 00000000 00000006",
                        lat, MD_Hi, MD_Lo);
    end
    extra = 0;
    tick();
    repeat (40) begin
      if (MD_Done || MD_Busy) extra++;
      tick();
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++; $display("FAIL no_second_op: got %0d busy/done samples expected 0", extra);
    end
  endtask

  task automatic test_early_out();
    int lat, bb;
    run_op(2'b01, 32'd5, 32'd0, lat, bb);
    n_vec++;
    if (lat !== EARLY_LAT || MD_Hi !== 32'h0 || MD_Lo !== 32'h0) begin
      n_err++; $display("FAIL multu_by_zero: got lat=%0d hi=%h lo=%h expected %0d 0 0",
                        lat, MD_Hi, MD_Lo, EARLY_LAT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    run_op(2'b01, 32'd3, 32'd4, lat, bb);
    n_vec++;
    if (MD_Hi !== 32'h0 || MD_Lo !== 32'd12) begin
      n_err++; $display("FAIL b2b_first: got hi=%h lo=%h expected 0 0000000c", MD_Hi, MD_Lo);
    end
    run_op(2'b11, 32'd100, 32'd7, lat, bb);
    n_vec++;
    if (lat !== 33 || bb !== 0 || MD_Hi !== 32'd2 || MD_Lo !== 32'd14) begin
      n_err++; $display("FAIL b2b_second: got lat=%0d idle=%0d hi=%h lo=%h expected 33 0 2 e",
                        lat, bb, MD_Hi, MD_Lo);
    end
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_mthi_mtlo();
    test_early_out();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
